// File: rtl/serial_word_receiver_if.sv
// Handshake/bus bundle for serial_word_receiver.
//   BIT_EN : bit strobe; SI is sampled only on clk edges where it is high
//   SI     : serial data line, idles high
//   ACK    : consumer acknowledge, clears VALID and OVR
//   Q      : last complete received word
//   VALID  : a word is waiting in Q and has not been acknowledged
//   BUSY   : a frame is in progress
//   FERR   : one-cycle pulse, the stop bit was sampled low
//   OVR    : sticky, a word completed while the previous one was unacknowledged
// The master side drives the serial line and consumes the word; the slave
// side is the receiver itself.
interface serial_word_receiver_if #(
  parameter int WIDTH = 4
);
  logic             BIT_EN;
  logic             SI;
  logic             ACK;
  logic [WIDTH-1:0] Q;
  logic             VALID;
  logic             BUSY;
  logic             FERR;
  logic             OVR;

  modport master (
    output BIT_EN, SI, ACK,
    input  Q, VALID, BUSY, FERR, OVR
  );

  modport slave (
    input  BIT_EN, SI, ACK,
    output Q, VALID, BUSY, FERR, OVR
  );
endinterface

// File: rtl/serial_word_receiver.sv
// Framed serial-to-parallel receiver.
// A frame is a start bit (0), WIDTH data bits and a stop bit (1); the line
// idles high. The received word is presented on Q with a level VALID/ACK
// handshake, plus a framing-error pulse (FERR) and a sticky overrun flag (OVR).
// Ports:
//   clk : system clock, all state changes on the rising edge
//   CR  : asynchronous active-low clear
//   bus : serial_word_receiver_if slave modport (BIT_EN, SI, ACK in;
//         Q, VALID, BUSY, FERR, OVR out)
// Parameters:
//   WIDTH     : data bits per frame (2..16)
//   MSB_FIRST : 1 = first data bit lands in Q[WIDTH-1], 0 = lands in Q[0]
module serial_word_receiver #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  CR,
  serial_word_receiver_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    cnt,   cnt_n;
  logic [WIDTH-1:0] q,     q_n;
  logic             valid, valid_n;
  logic             busy,  busy_n;
  logic             ferr,  ferr_n;
  logic             ovr,   ovr_n;

  // Next-state and next-output logic.
  // NOTE: every variable gets a default at the top of the block so that no
  // path leaves one unassigned; a missing default would infer a latch.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    q_n     = q;
    valid_n = valid;
    ovr_n   = ovr;
    ferr_n  = 1'b0;

    // Acknowledge works regardless of the bit strobe; an ACK with nothing
    // pending is ignored.
    if (bus.ACK && valid) begin
      valid_n = 1'b0;
      ovr_n   = 1'b0;
    end

    if (bus.BIT_EN) begin
      unique case (state)
        IDLE: begin
          // A single low sample is taken as a start bit (no oversampling).
          if (!bus.SI) begin
            state_n = DATA;
            cnt_n   = '0;
          end
        end

        DATA: begin
          if (MSB_FIRST) begin
            shreg_n = {shreg[WIDTH-2:0], bus.SI};
          end else begin
            shreg_n = {bus.SI, shreg[WIDTH-1:1]};
          end
          cnt_n = cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state_n = STOP;
          end
        end

        STOP: begin
          state_n = IDLE;
          if (bus.SI) begin
            // A completing word always wins, even against a same-edge ACK;
            // overrun is flagged only if the old word is left unacknowledged.
            q_n     = shreg;
            valid_n = 1'b1;
            if (valid && !bus.ACK) begin
              ovr_n = 1'b1;
            end
          end else begin
            ferr_n = 1'b1;
          end
        end

        default: state_n = IDLE;
      endcase
    end

    busy_n = (state_n != IDLE);
  end

  // State and output registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge CR) begin
    if (!CR) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      q     <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      ferr  <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      cnt   <= cnt_n;
      q     <= q_n;
      valid <= valid_n;
      busy  <= busy_n;
      ferr  <= ferr_n;
      ovr   <= ovr_n;
    end
  end

  assign bus.Q     = q;
  assign bus.VALID = valid;
  assign bus.BUSY  = busy;
  assign bus.FERR  = ferr;
  assign bus.OVR   = ovr;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver (WIDTH=4). Two receivers, one
// MSB-first and one LSB-first, listen to the same serial line; expected
// words are queued when a frame is sent and compared after its stop bit.
module tb_serial_word_receiver;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] msb;
    logic [W-1:0] lsb;
  } exp_t;

  logic clk;
  logic CR;
  int   n_checks;
  int   n_fail;
  int   busy_cycles;
  exp_t sb_q[$];

  serial_word_receiver_if #(.WIDTH(W)) m_if ();
  serial_word_receiver_if #(.WIDTH(W)) l_if ();

  // The LSB-first receiver sees exactly the same line and handshake.
  assign l_if.BIT_EN = m_if.BIT_EN;
  assign l_if.SI     = m_if.SI;
  assign l_if.ACK    = m_if.ACK;

  serial_word_receiver #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk (clk),
    .CR  (CR),
    .bus (m_if.slave)
  );

  serial_word_receiver #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk (clk),
    .CR  (CR),
    .bus (l_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one frame: start, data MSB of w first, stop. gap = idle clocks
  // between strobes (SI toggles during them). ack_at_stop raises ACK on the
  // stop-bit edge. Returns with outputs sampled just after the stop edge.
  task automatic send_frame(input logic [W-1:0] w, input logic stop,
                            input int gap, input logic ack_at_stop, input string tag);
    logic [5:0] stream;
    exp_t       e;
    stream = {stop, w[0], w[1], w[2], w[3], 1'b0};
    if (stop) sb_q.push_back('{msb: w, lsb: rev(w)});
    busy_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      m_if.SI     = stream[i];
      m_if.BIT_EN = 1'b1;
      m_if.ACK    = (i == 5) ? ack_at_stop : 1'b0;
      step();
      m_if.BIT_EN = 1'b0;
      m_if.ACK    = 1'b0;
      if (m_if.BUSY) busy_cycles++;
      if (i < 5) begin
        for (int g = 0; g < gap; g++) begin
          m_if.SI = ~m_if.SI;
          step();
          if (m_if.BUSY) busy_cycles++;
        end
      end
    end
    m_if.SI = 1'b1;
    if (stop) begin
      if (sb_q.size() == 0) begin
        check({tag, " scoreboard"}, 16'd0, 16'd1);
      end else begin
        e = sb_q.pop_front();
        check({tag, " q_msb"}, 16'(m_if.Q), 16'(e.msb));
        check({tag, " q_lsb"}, 16'(l_if.Q), 16'(e.lsb));
      end
    end
  endtask

  task automatic ack_cycle();
    m_if.ACK = 1'b1;
    step();
    m_if.ACK = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    m_if.BIT_EN = 1'b0;
    m_if.SI     = 1'b1;
    m_if.ACK    = 1'b0;
    CR          = 1'b1;
    #2 CR = 1'b0;
    #1;
    check("reset Q",     16'(m_if.Q), 16'h0);
    check("reset VALID", 16'(m_if.VALID), 16'h0);
    check("reset BUSY",  16'(m_if.BUSY), 16'h0);
    check("reset FERR",  16'(m_if.FERR), 16'h0);
    check("reset OVR",   16'(m_if.OVR), 16'h0);
    repeat (2) @(posedge clk);
    #1 CR = 1'b1;
    step();

    // Full-rate 4'hB.
    send_frame(4'hB, 1'b1, 0, 1'b0, "fullrate");
    check("fullrate VALID",    16'(m_if.VALID), 16'h1);
    check("fullrate VALIDlsb", 16'(l_if.VALID), 16'h1);
    check("fullrate busy_len", 16'(busy_cycles), 16'd5);
    check("fullrate BUSY",     16'(m_if.BUSY), 16'h0);
    check("fullrate FERR",     16'(m_if.FERR), 16'h0);
    check("fullrate OVR",      16'(m_if.OVR), 16'h0);
    ack_cycle();
    check("ack VALID", 16'(m_if.VALID), 16'h0);

    // Stop bit low: framing error, word discarded.
    send_frame(4'hF, 1'b0, 0, 1'b0, "ferr");
    check("ferr FERR",  16'(m_if.FERR), 16'h1);
    check("ferr Q",     16'(m_if.Q), 16'hB);
    check("ferr VALID", 16'(m_if.VALID), 16'h0);
    check("ferr BUSY",  16'(m_if.BUSY), 16'h0);
    step();
    check("ferr pulse", 16'(m_if.FERR), 16'h0);

    // Back-to-back frames without ACK: overrun.
    send_frame(4'hB, 1'b1, 0, 1'b0, "ovr1");
    check("ovr1 OVR", 16'(m_if.OVR), 16'h0);
    send_frame(4'h6, 1'b1, 0, 1'b0, "ovr2");
    check("ovr2 OVR",   16'(m_if.OVR), 16'h1);
    check("ovr2 VALID", 16'(m_if.VALID), 16'h1);
    ack_cycle();
    check("ovr ack VALID", 16'(m_if.VALID), 16'h0);
    check("ovr ack OVR",   16'(m_if.OVR), 16'h0);

    // Strobe every 3rd clock, SI toggling between strobes.
    send_frame(4'h5, 1'b1, 2, 1'b0, "slow");
    check("slow VALID", 16'(m_if.VALID), 16'h1);
    check("slow FERR",  16'(m_if.FERR), 16'h0);
    check("slow OVR",   16'(m_if.OVR), 16'h0);
    step();
    check("slow hold Q", 16'(m_if.Q), 16'h5);

    // ACK on the completing edge: new word wins, no overrun.
    send_frame(4'h6, 1'b1, 0, 1'b1, "ackwin");
    check("ackwin VALID", 16'(m_if.VALID), 16'h1);
    check("ackwin OVR",   16'(m_if.OVR), 16'h0);

    // Clear mid-frame of 4'hF after two data bits.
    m_if.BIT_EN = 1'b1;
    m_if.SI = 1'b0; step();
    m_if.SI = 1'b1; step();
    m_if.SI = 1'b1; step();
    m_if.BIT_EN = 1'b0;
    check("midframe BUSY", 16'(m_if.BUSY), 16'h1);
    CR = 1'b0;
    #1;
    check("async Q",     16'(m_if.Q), 16'h0);
    check("async VALID", 16'(m_if.VALID), 16'h0);
    check("async BUSY",  16'(m_if.BUSY), 16'h0);
    check("async FERR",  16'(m_if.FERR), 16'h0);
    check("async OVR",   16'(m_if.OVR), 16'h0);
    #1 CR = 1'b1;
    step();
    send_frame(4'h3, 1'b1, 0, 1'b0, "after_cr");
    check("after_cr VALID", 16'(m_if.VALID), 16'h1);
    check("after_cr FERR",  16'(m_if.FERR), 16'h0);
    check("after_cr OVR",   16'(m_if.OVR), 16'h0);
    check("scoreboard empty", 16'(sb_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
